key_switch_conditioner: RTL
===========================

// Module: key_switch_conditioner
// PURPOSE
//  Front end for the NIOS system's key and switch PIO inputs. Conditions raw pushbuttons and slide switches before they reach the PIOs.
//  Per input: 2-FF synchroniser, then a debounce counter. Debounced key levels feed the pio_key_* ports; debounced switches feed pio_switches.
//  Also produces one-cycle press pulses with optional auto-repeat, for clock set/adjust logic.
// PARAMETERS
//  NUM_KEYS        4           number of pushbuttons
//  NUM_SW          2           number of slide switches
//  KEY_ACTIVE_LOW  1           1: raw key reads 0 when pressed (board keys); 0: active-high
//  DEBOUNCE_CYCLES 50000       consecutive stable cycles required to accept a change (>=2)
//  REPEAT_DELAY    25000000    cycles from press pulse to first repeat pulse (>=2)
//  REPEAT_RATE     5000000     cycles between subsequent repeat pulses (>=2)
//  REPEAT_MASK     4'b0000     bit i=1 enables auto-repeat on key i
// PORTS
//  clk_clk        in   1         system clock, all logic on rising edge
//  reset_reset_n  in   1         synchronous, active-low reset
//  key_raw        in   NUM_KEYS  asynchronous raw pushbuttons
//  sw_raw         in   NUM_SW    asynchronous raw switches
//  key_level      out  NUM_KEYS  debounced key state, 1 = pressed (polarity normalised)
//  key_pulse      out  NUM_KEYS  1-cycle strobe on accepted press and on each repeat
//  sw_level       out  NUM_SW    debounced switch state, same polarity as sw_raw
// BEHAVIOUR
//  Reset (reset_reset_n=0 at a clk edge):
//   - Sync FFs load the released value: ~KEY_ACTIVE_LOW for keys, 0 for switches.
//   - key_level=0, key_pulse=0, sw_level=0, all counters=0, every key FSM=IDLE.
//  Synchroniser: s1<=raw; s2<=s1. Key sample k = s2 XOR KEY_ACTIVE_LOW.
//  Debounce, per input (stable register S, counter C, width $clog2(DEBOUNCE_CYCLES)):
//   - sample==S: C<=0.
//   - sample!=S and C<DEBOUNCE_CYCLES-1: C<=C+1.
//   - sample!=S and C==DEBOUNCE_CYCLES-1: S<=sample, C<=0.
//   - Any glitch back to S before terminal count restarts the count; no output change.
//  Latency: raw stable from edge E -> level changes at clock E+2+DEBOUNCE_CYCLES, exactly.
//  key_level = S (registered). sw_level = S for switches. Switches never pulse.
//  Key FSM, per key (repeat counter R, width $clog2(max(REPEAT_DELAY,REPEAT_RATE))):
//   - IDLE: on S 0->1, assert key_pulse for that same cycle.
//       If REPEAT_MASK[i]: R<=0, go to DELAY. Else go to HELD.
//   - HELD: on S 1->0, go to IDLE. No pulse.
//   - DELAY: R increments each cycle. At R==REPEAT_DELAY-1: pulse, R<=0, go to RPT.
//   - RPT: R increments each cycle. At R==REPEAT_RATE-1: pulse, R<=0.
//   - DELAY/RPT: S 1->0 -> IDLE, R<=0, no pulse. Release takes priority over a coincident repeat.
//  Pulse spacing: 1st at press; 2nd REPEAT_DELAY cycles later; then every REPEAT_RATE cycles.
//  Release yields no pulse. key_pulse never exceeds 1 cycle and never occurs while key_level=0.
//  Keys are fully independent; simultaneous presses pulse in the same cycle.
//  Reset mid-operation: state cleared at once, no pulse on that cycle.
//   A key still held after reset release is re-accepted at E+2+DEBOUNCE_CYCLES, E = first non-reset edge.
//  All outputs registered; no combinational path from raw inputs to outputs.
// TESTING (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, REPEAT_MASK=4'b0001, KEY_ACTIVE_LOW=1)
//  1. Hold reset 3 cycles with key_raw=4'hF, sw_raw=0 -> all outputs 0. Release -> still 0 for 50 cycles.
//  2. key_raw[1]=0 held from edge E -> key_level[1]=1 and key_pulse[1]=1 at E+6 only.
//     Release -> key_level[1]=0 at release+6, no pulse, no repeat.
//  3. key_raw[2] bounces 0,1,0,1 (1-cycle each), then 0 held -> exactly one key_pulse[2].
//     Timing follows the last bounce edge per latency rule.
//  4. Hold key 0 for 60 cycles after acceptance -> pulses at offsets 0, 20, 28, 36, 44, 52.
//     Release -> no further pulse.
//  5. sw_raw=2'b10 from E -> sw_level=2'b10 at E+6. 3-cycle glitch on sw_raw[0] -> sw_level unchanged.
//  6. Key 0 in RPT, reset asserted 1 cycle -> outputs 0 that cycle.
//     Key still held -> re-accepted 6 cycles after reset release, then first repeat 20 cycles later.

Source files
------------

// File: rtl/key_switch_conditioner.sv
// key_switch_conditioner
//   Conditions the raw board pushbuttons and slide switches before they reach
//   the key/switch PIOs.
//   - Every input passes through a 2-FF synchroniser and then a debounce
//     counter. A change is accepted only after DEBOUNCE_CYCLES stable samples.
//   - Every key also has a small FSM. It emits a one-cycle press pulse and,
//     where REPEAT_MASK enables it, auto-repeat pulses for set/adjust logic.
// Ports
//   clk_clk        system clock, rising edge
//   reset_reset_n  synchronous active-low reset
//   key_raw        raw pushbuttons (asynchronous)
//   sw_raw         raw slide switches (asynchronous)
//   key_level      debounced key state, 1 = pressed
//   key_pulse      one-cycle strobe on accepted press and on each repeat
//   sw_level       debounced switch state, same polarity as sw_raw
module key_switch_conditioner #(
   parameter int                  NUM_KEYS        = 4,
   parameter int                  NUM_SW          = 2,
   parameter int                  KEY_ACTIVE_LOW  = 1,
   parameter int                  DEBOUNCE_CYCLES = 50000,
   parameter int                  REPEAT_DELAY    = 25000000,
   parameter int                  REPEAT_RATE     = 5000000,
   parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = '0
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [NUM_KEYS-1:0] key_raw,
   input  logic [NUM_SW-1:0]   sw_raw,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_pulse,
   output logic [NUM_SW-1:0]   sw_level
);

   localparam int NUM_IN  = NUM_KEYS + NUM_SW;
   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX);

   localparam logic              KAL        = (KEY_ACTIVE_LOW != 0);
   // Raw level of an idle input. The synchroniser is reset to this value so
   // that releasing reset never looks like a press.
   localparam logic [NUM_IN-1:0] SYNC_RST   = {{NUM_SW{1'b0}}, {NUM_KEYS{KAL}}};
   // XOR mask that turns every key into "1 = pressed". Switches pass through.
   localparam logic [NUM_IN-1:0] POL_MASK   = {{NUM_SW{1'b0}}, {NUM_KEYS{KAL}}};
   localparam logic [DB_W-1:0]   DB_TERM    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0]  DELAY_TERM = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0]  RATE_TERM  = RPT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HELD  = 2'd1,
      DELAY = 2'd2,
      RPT   = 2'd3
   } key_state_e;

   logic [NUM_IN-1:0]   s1_q;
   logic [NUM_IN-1:0]   s2_q;
   logic [NUM_IN-1:0]   sample;
   logic [NUM_IN-1:0]   lvl_cur;    // accepted (stable) level of each input
   logic [NUM_KEYS-1:0] key_next;   // accepted level a key takes at the next edge

   // Two-flop synchroniser, shared by keys and switches.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         s1_q <= SYNC_RST;
         s2_q <= SYNC_RST;
      end else begin
         s1_q <= {sw_raw, key_raw};
         s2_q <= s1_q;
      end
   end

   assign sample = s2_q ^ POL_MASK;

   // Debounce. The counter only runs while the sample differs from the
   // accepted level. Any return to that level clears the count.
   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_db
      logic            st_q;
      logic            st_d;
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;

      always_comb begin
         st_d  = st_q;
         cnt_d = '0;
         if (sample[gi] != st_q) begin
            if (cnt_q == DB_TERM) begin
               st_d = sample[gi];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk_clk) begin
         if (!reset_reset_n) begin
            st_q  <= 1'b0;
            cnt_q <= '0;
         end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
         end
      end

      assign lvl_cur[gi] = st_q;

      if (gi < NUM_KEYS) begin : g_key_next
         assign key_next[gi] = st_d;
      end
   end

   // Per-key press / auto-repeat FSM. The FSM watches the debounce next-state,
   // so the press pulse is registered on the same edge as key_level rises.
   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_state_e       state_q;
      key_state_e       state_d;
      logic [RPT_W-1:0] rcnt_q;
      logic [RPT_W-1:0] rcnt_d;
      logic             pulse_q;
      logic             pulse_d;
      logic             rise;
      logic             fall;

      assign rise = key_next[gi] & ~lvl_cur[gi];
      assign fall = ~key_next[gi] & lvl_cur[gi];

      always_comb begin
         state_d = state_q;
         rcnt_d  = rcnt_q;
         pulse_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (rise) begin
                  pulse_d = 1'b1;
                  rcnt_d  = '0;
                  state_d = REPEAT_MASK[gi] ? DELAY : HELD;
               end
            end
            HELD: begin
               if (fall) begin
                  state_d = IDLE;
               end
            end
            DELAY, RPT: begin
               // Release wins over a repeat that falls due on the same edge.
               if (fall) begin
                  state_d = IDLE;
                  rcnt_d  = '0;
               end else if (rcnt_q == ((state_q == DELAY) ? DELAY_TERM : RATE_TERM)) begin
                  pulse_d = 1'b1;
                  rcnt_d  = '0;
                  state_d = RPT;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               rcnt_d  = '0;
            end
         endcase
      end

      always_ff @(posedge clk_clk) begin
         if (!reset_reset_n) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            pulse_q <= 1'b0;
         end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            pulse_q <= pulse_d;
         end
      end

      assign key_pulse[gi] = pulse_q;
   end

   assign key_level = lvl_cur[NUM_KEYS-1:0];
   assign sw_level  = lvl_cur[NUM_IN-1:NUM_KEYS];

endmodule
